// File: rtl/mac_pkg.sv
// Shared formats, constants and helpers for the MAC normalize/round/pack path.
package mac_pkg;

  typedef enum logic [1:0] {
    MODE_BF16 = 2'b00,
    MODE_FP8  = 2'b01,
    MODE_RSVD = 2'b10,
    MODE_INT4 = 2'b11
  } mode_e;

  localparam int BF16_BIAS   = 127;
  localparam int FP8_BIAS    = 7;
  localparam int BF16_MANT_W = 7;
  localparam int FP8_MANT_W  = 3;
  localparam int BF16_EXP_W  = 8;
  localparam int FP8_EXP_W   = 4;

  // FP8 E4M3 largest finite magnitude: exponent 1111, mantissa 110
  localparam logic [6:0] FP8_MAX_NORMAL = {{FP8_EXP_W{1'b1}}, 3'b110};

  // Magnitude is handled in one 17-bit frame; FP8 is left-justified into it
  localparam int NORM_W = 17;
  localparam int LZ_W   = $clog2(NORM_W + 1);

  // Signed exponent wide enough for underflow below 0 and overflow past 255
  typedef logic signed [9:0] sexp_t;

  localparam sexp_t BF16_EXP_INF = sexp_t'(2 * BF16_BIAS + 1);
  localparam sexp_t FP8_EXP_MAX  = sexp_t'(2 * FP8_BIAS + 1);

  // Place the magnitude so that its top bit is always bit NORM_W-1
  function automatic logic [NORM_W-1:0] align_mag(input mode_e m, input logic c,
                                                  input logic [15:0] s);
    if (m == MODE_FP8) return {c, s[7:0], 8'h00};
    return {c, s};
  endfunction

endpackage

// File: rtl/norm_round_pack_lzc.sv
// Parameterised leading-zero counter; count equals W when the input is all zero.
module lzc #(
  parameter int W = 17
) (
  input  logic [W-1:0]           data,
  output logic [$clog2(W+1)-1:0] count,
  output logic                   all_zero
);

  localparam int CW = $clog2(W + 1);

  // Scan upward so the highest set bit has the final say on the count
  always_comb begin
    count    = CW'(W);
    all_zero = (data == '0);
    for (int i = 0; i < W; i++) begin
      if (data[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/norm_round_pack.sv
// Two-stage normalize, round-to-nearest-even, saturate and pack for BF16/FP8/INT4.
module norm_round_pack #(
  parameter int SUM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [SUM_W-1:0] sum,
  input  logic             cout,
  input  logic             sign,
  input  logic [7:0]       exp_max,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      result,
  output logic             ovf,
  output logic             unf,
  output logic             inexact
);

  import mac_pkg::*;

  logic              adv;
  logic [NORM_W-1:0] mag_in;
  logic [LZ_W-1:0]   lz_in;
  logic              zero_in;
  sexp_t             exp_in;

  logic              s1_valid;
  mode_e             s1_mode;
  logic              s1_sign;
  logic              s1_cout;
  logic [15:0]       s1_sum;
  logic [LZ_W-1:0]   s1_lz;
  logic              s1_zero;
  sexp_t             s1_exp;

  logic [15:0]           frac;
  logic                  guard;
  logic                  sticky;
  logic                  lsb;
  logic                  round_up;
  logic [BF16_MANT_W:0]  mant_b;
  logic [FP8_MANT_W:0]   mant_f;
  logic                  carry;
  sexp_t                 exp_r;

  logic [15:0] res_n;
  logic        ovf_n;
  logic        unf_n;
  logic        inx_n;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  assign mag_in   = align_mag(mode_e'(mode), cout, sum[15:0]);

  lzc #(.W(NORM_W)) u_lzc (
    .data     (mag_in),
    .count    (lz_in),
    .all_zero (zero_in)
  );

  // Unbiased-offset exponent: both formats reduce to exp_max + 2 - leading zeros
  always_comb begin
    if (mode == MODE_FP8) exp_in = sexp_t'(exp_max[3:0]) + sexp_t'(2) - sexp_t'(lz_in);
    else                  exp_in = sexp_t'(exp_max) + sexp_t'(2) - sexp_t'(lz_in);
  end

  // Normalize the stage-1 magnitude, then round to nearest even
  always_comb begin
    frac     = 16'(align_mag(s1_mode, s1_cout, s1_sum) << s1_lz);
    guard    = 1'b0;
    sticky   = 1'b0;
    lsb      = 1'b0;
    if (s1_mode == MODE_FP8) begin
      lsb    = frac[16 - FP8_MANT_W];
      guard  = frac[15 - FP8_MANT_W];
      sticky = |frac[14 - FP8_MANT_W:0];
    end else begin
      lsb    = frac[16 - BF16_MANT_W];
      guard  = frac[15 - BF16_MANT_W];
      sticky = |frac[14 - BF16_MANT_W:0];
    end
    round_up = guard & (sticky | lsb);
    mant_b   = {1'b0, frac[15 -: BF16_MANT_W]} + {{BF16_MANT_W{1'b0}}, round_up};
    mant_f   = {1'b0, frac[15 -: FP8_MANT_W]} + {{FP8_MANT_W{1'b0}}, round_up};
    carry    = (s1_mode == MODE_FP8) ? mant_f[FP8_MANT_W] : mant_b[BF16_MANT_W];
    exp_r    = s1_exp + sexp_t'(carry);
  end

  // Saturate, flush and pack per format into the next output word and flags
  always_comb begin
    res_n = '0;
    ovf_n = 1'b0;
    unf_n = 1'b0;
    inx_n = 1'b0;
    case (s1_mode)
      MODE_BF16: begin
        if (s1_zero) begin
          res_n = {s1_sign, 15'h0000};
        end else begin
          inx_n = guard | sticky;
          if (exp_r >= BF16_EXP_INF) begin
            res_n = {s1_sign, {BF16_EXP_W{1'b1}}, {BF16_MANT_W{1'b0}}};
            ovf_n = 1'b1;
          end else if (exp_r <= sexp_t'(0)) begin
            res_n = {s1_sign, 15'h0000};
            unf_n = 1'b1;
          end else begin
            res_n = {s1_sign, exp_r[BF16_EXP_W-1:0], mant_b[BF16_MANT_W-1:0]};
          end
        end
      end
      MODE_FP8: begin
        if (s1_zero) begin
          res_n = {8'h00, s1_sign, 7'h00};
        end else begin
          inx_n = guard | sticky;
          if ((exp_r > FP8_EXP_MAX) ||
              ((exp_r == FP8_EXP_MAX) && (mant_f[FP8_MANT_W-1:0] == 3'b111))) begin
            res_n = {8'h00, s1_sign, FP8_MAX_NORMAL};
            ovf_n = 1'b1;
          end else if (exp_r <= sexp_t'(0)) begin
            res_n = {8'h00, s1_sign, 7'h00};
            unf_n = 1'b1;
          end else begin
            res_n = {8'h00, s1_sign, exp_r[FP8_EXP_W-1:0], mant_f[FP8_MANT_W-1:0]};
          end
        end
      end
      MODE_INT4: begin
        res_n = s1_sum;
        ovf_n = s1_cout;
      end
      default: begin
        res_n = '0;
      end
    endcase
  end

  // Both pipeline stages move together on adv; the output only loads real beats
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mode   <= MODE_BF16;
      s1_sign   <= 1'b0;
      s1_cout   <= 1'b0;
      s1_sum    <= '0;
      s1_lz     <= '0;
      s1_zero   <= 1'b0;
      s1_exp    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      inexact   <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_mode   <= mode_e'(mode);
      s1_sign   <= sign;
      s1_cout   <= cout;
      s1_sum    <= sum[15:0];
      s1_lz     <= lz_in;
      s1_zero   <= zero_in;
      s1_exp    <= exp_in;
      out_valid <= s1_valid;
      if (s1_valid) begin
        result  <= res_n;
        ovf     <= ovf_n;
        unf     <= unf_n;
        inexact <= inx_n;
      end
    end
  end

endmodule

// File: tb/tb_norm_round_pack.sv
// Self-checking bench for norm_round_pack: directed corner cases plus random streams.
module tb_norm_round_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [15:0] sum;
  logic        cout;
  logic        sign;
  logic [7:0]  exp_max;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        ovf;
  logic        unf;
  logic        inexact;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]  mode;
    logic [15:0] sum;
    logic        cout;
    logic        sign;
    logic [7:0]  exp_max;
  } beat_t;

  typedef struct packed {
    logic [15:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
  } resp_t;

  beat_t sendQ[$];
  resp_t expQ[$];

  norm_round_pack #(.SUM_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sum       (sum),
    .cout      (cout),
    .sign      (sign),
    .exp_max   (exp_max),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .unf       (unf),
    .inexact   (inexact)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  function automatic beat_t mkBeat(input logic [1:0] m, input logic [15:0] s, input logic c,
                                   input logic sg, input logic [7:0] e);
    beat_t b;
    b.mode = m; b.sum = s; b.cout = c; b.sign = sg; b.exp_max = e;
    return b;
  endfunction

  function automatic resp_t mkResp(input logic [15:0] r, input logic o, input logic u,
                                   input logic i);
    resp_t x;
    x.res = r; x.ovf = o; x.unf = u; x.inx = i;
    return x;
  endfunction

  function automatic beat_t randBeat();
    beat_t b;
    int r;
    r = $urandom_range(0, 9);
    b.mode    = (r < 5) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b11 : 2'b10;
    b.sum     = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
    b.cout    = ($urandom_range(0, 3) == 0);
    b.sign    = 1'($urandom_range(0, 1));
    b.exp_max = 8'($urandom_range(0, 255));
    return b;
  endfunction

  // Reference: value-level rounding via quotient/remainder of the fraction
  function automatic resp_t refModel(input beat_t b);
    resp_t r;
    int mag, pt, mw, lead, frac, sh, q, rem, half, e;
    bit isBf;
    r = '0;
    if (b.mode == 2'b11) begin r.res = b.sum; r.ovf = b.cout; return r; end
    if (b.mode == 2'b10) return r;
    isBf = (b.mode == 2'b00);
    if (isBf) begin
      mag = int'({b.cout, b.sum}); pt = 14; mw = 7; e = int'(b.exp_max);
    end else begin
      mag = int'({b.cout, b.sum[7:0]}); pt = 6; mw = 3; e = int'(b.exp_max[3:0]);
    end
    if (mag == 0) begin
      r.res = isBf ? {b.sign, 15'h0000} : {8'h00, b.sign, 7'h00};
      return r;
    end
    lead = 0;
    while ((mag >> (lead + 1)) != 0) lead++;
    frac = mag - (1 << lead);
    if (lead > mw) begin
      sh   = lead - mw;
      q    = frac >> sh;
      rem  = frac - (q << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      r.inx = (rem != 0);
    end else begin
      q = frac << (mw - lead);
    end
    e = e + lead - pt;
    if (q == (1 << mw)) begin q = 0; e++; end
    if (isBf) begin
      if (e >= 255) begin r.res = {b.sign, 8'hFF, 7'h00}; r.ovf = 1'b1; end
      else if (e <= 0) begin r.res = {b.sign, 15'h0000}; r.unf = 1'b1; end
      else r.res = {b.sign, 8'(e), 7'(q)};
    end else begin
      if (e > 15 || (e == 15 && q == 7)) begin r.res = {8'h00, b.sign, 7'h7E}; r.ovf = 1'b1; end
      else if (e <= 0) begin r.res = {8'h00, b.sign, 7'h00}; r.unf = 1'b1; end
      else r.res = {8'h00, b.sign, 4'(e), 3'(q)};
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input resp_t e);
    resp_t o;
    o = {result, ovf, unf, inexact};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("[TB] FAIL %s: observed res=%h ovf=%b unf=%b inx=%b, expected res=%h ovf=%b unf=%b inx=%b",
             tag, o.res, o.ovf, o.unf, o.inx, e.res, e.ovf, e.unf, e.inx);
    end
  endtask

  task automatic checkBit(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("[TB] FAIL %s: observed %b, expected %b", tag, o, e);
    end
  endtask

  task automatic checkInt(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, o, e);
    end
  endtask

  task automatic driveBeat(input beat_t b);
    mode = b.mode; sum = b.sum; cout = b.cout; sign = b.sign; exp_max = b.exp_max;
  endtask

  task automatic applyStimulus(input beat_t b, input resp_t e);
    sendQ.push_back(b);
    expQ.push_back(e);
  endtask

  // readyMode: 0 always ready, 1 random ready and input gaps, 2 stall in cycles 2..4
  task automatic drainStream(input int readyMode, input int budget, output int cyclesUsed);
    int  cyc;
    bit  accept;
    bit  gap;
    cyc = 0;
    while ((sendQ.size() > 0 || expQ.size() > 0) && cyc < budget) begin
      gap = (readyMode == 1) && ($urandom_range(0, 3) == 0);
      if (sendQ.size() > 0 && !gap) begin
        driveBeat(sendQ[0]);
        in_valid = 1'b1;
      end else begin
        driveBeat(randBeat());
        in_valid = 1'b0;
      end
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = !(cyc >= 2 && cyc <= 4);
      endcase
      #1;
      accept = in_valid && in_ready;
      if (out_valid && out_ready) begin
        checkBit("noExtraBeat", (expQ.size() > 0), 1'b1);
        if (expQ.size() > 0) checkOutput("streamBeat", expQ.pop_front());
      end else if (out_valid && !out_ready) begin
        checkBit("stallInReady", in_ready, 1'b0);
        if (expQ.size() > 0) checkOutput("stallHold", expQ[0]);
      end
      @(posedge clk); #1;
      if (accept) void'(sendQ.pop_front());
      cyc++;
    end
    in_valid   = 1'b0;
    cyclesUsed = cyc;
    checkBit("drainComplete", (sendQ.size() == 0 && expQ.size() == 0), 1'b1);
    sendQ.delete();
    expQ.delete();
  endtask

  // Directed corner cases, backpressure, random traffic, throughput and mid-flight reset
  initial begin
    int    cyc;
    beat_t b;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    driveBeat(mkBeat(2'b00, 16'h0000, 1'b0, 1'b0, 8'h00));
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetState", mkResp(16'h0000, 1'b0, 1'b0, 1'b0));
    checkBit("resetOutValid", out_valid, 1'b0);
    rst = 1'b0;
    #1;
    checkBit("readyAfterReset", in_ready, 1'b1);
    @(posedge clk); #1;

    applyStimulus(mkBeat(2'b00, 16'h4000, 1'b0, 1'b0, 8'd127), mkResp(16'h3F80, 1'b0, 1'b0, 1'b0));
    drainStream(0, 20, cyc);
    checkInt("bf16UnityLatency", cyc, 3);

    applyStimulus(mkBeat(2'b00, 16'h0000, 1'b1, 1'b0, 8'd127), mkResp(16'h4080, 1'b0, 1'b0, 1'b0));
    applyStimulus(mkBeat(2'b00, 16'h4040, 1'b0, 1'b0, 8'd127), mkResp(16'h3F80, 1'b0, 1'b0, 1'b1));
    applyStimulus(mkBeat(2'b00, 16'h40C0, 1'b0, 1'b0, 8'd127), mkResp(16'h3F82, 1'b0, 1'b0, 1'b1));
    applyStimulus(mkBeat(2'b00, 16'h0000, 1'b1, 1'b0, 8'd254), mkResp(16'h7F80, 1'b1, 1'b0, 1'b0));
    applyStimulus(mkBeat(2'b00, 16'h0100, 1'b0, 1'b1, 8'd1),   mkResp(16'h8000, 1'b0, 1'b1, 1'b0));
    applyStimulus(mkBeat(2'b01, 16'h0040, 1'b0, 1'b0, 8'd7),   mkResp(16'h0038, 1'b0, 1'b0, 1'b0));
    applyStimulus(mkBeat(2'b01, 16'h0000, 1'b1, 1'b0, 8'd15),  mkResp(16'h007E, 1'b1, 1'b0, 1'b0));
    applyStimulus(mkBeat(2'b01, 16'h0044, 1'b0, 1'b0, 8'd7),   mkResp(16'h0038, 1'b0, 1'b0, 1'b1));
    applyStimulus(mkBeat(2'b01, 16'h0078, 1'b0, 1'b1, 8'd15),  mkResp(16'h00FE, 1'b1, 1'b0, 1'b0));
    applyStimulus(mkBeat(2'b00, 16'h0000, 1'b0, 1'b1, 8'd90),  mkResp(16'h8000, 1'b0, 1'b0, 1'b0));
    applyStimulus(mkBeat(2'b11, 16'h1234, 1'b1, 1'b0, 8'd0),   mkResp(16'h1234, 1'b1, 1'b0, 1'b0));
    applyStimulus(mkBeat(2'b10, 16'hFFFF, 1'b1, 1'b1, 8'd200), mkResp(16'h0000, 1'b0, 1'b0, 1'b0));
    drainStream(0, 50, cyc);
    checkInt("directedBackToBack", cyc, 12 + 2);

    for (int i = 0; i < 4; i++) begin
      b = randBeat();
      b.mode = 2'b00;
      applyStimulus(b, refModel(b));
    end
    drainStream(2, 50, cyc);
    $display("[TB] backpressure stream took %0d cycles", cyc);

    for (int i = 0; i < 200; i++) begin
      b = randBeat();
      applyStimulus(b, refModel(b));
    end
    drainStream(1, 3000, cyc);

    for (int i = 0; i < 50; i++) begin
      b = randBeat();
      applyStimulus(b, refModel(b));
    end
    drainStream(0, 200, cyc);
    checkInt("throughputCycles", cyc, 50 + 2);

    out_ready = 1'b0;
    driveBeat(mkBeat(2'b00, 16'h4000, 1'b0, 1'b0, 8'd127));
    in_valid = 1'b1;
    #1;
    checkBit("rstAcceptA", in_ready, 1'b1);
    @(posedge clk); #1;
    driveBeat(mkBeat(2'b00, 16'h8000, 1'b1, 1'b1, 8'd100));
    #1;
    checkBit("rstAcceptB", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    checkBit("rstOutValidBefore", out_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkBit("rstOutValid", out_valid, 1'b0);
    checkOutput("rstFlush", mkResp(16'h0000, 1'b0, 1'b0, 1'b0));
    checkBit("rstInReady", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkBit("rstNoStale", out_valid, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
